// File: rtl/keypad_decoder_pkg.sv
// Shared types and helpers for the keypad column decoder: FSM states,
// keypad geometry, the key map and a one-hot to index converter.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_t;

    // Physical keypad legend, rows top to bottom, columns left to right
    function automatic logic [3:0] decode_key(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic onehot_t onehot_idx(input logic [3:0] vec);
        onehot_t res;
        res = '0;
        case (vec)
            4'b0001: res = '{valid: 1'b1, idx: 2'd0};
            4'b0010: res = '{valid: 1'b1, idx: 2'd1};
            4'b0100: res = '{valid: 1'b1, idx: 2'd2};
            4'b1000: res = '{valid: 1'b1, idx: 2'd3};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_decoder_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Column-side keypad decoder: paces the row sweeper, locks onto a single
// pressed key, debounces press and release, and reports the hex key code.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    output logic       scan_en,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] db_cnt;
    logic [1:0]       row_lock;
    logic [1:0]       col_lock;
    logic [3:0]       cols_s;
    onehot_t          row_oh;
    onehot_t          col_oh;
    logic             locked_bit;

    sync2 #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (cols_s)
    );

    always_comb begin
        row_oh     = onehot_idx(rows);
        col_oh     = onehot_idx(cols_s);
        locked_bit = cols_s[col_lock];
    end

    // Only the locked column matters once a key is captured; others are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            div_cnt   <= '0;
            db_cnt    <= '0;
            row_lock  <= '0;
            col_lock  <= '0;
            scan_en   <= 1'b0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            scan_en   <= 1'b0;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (row_oh.valid && col_oh.valid) begin
                            row_lock <= row_oh.idx;
                            col_lock <= col_oh.idx;
                            db_cnt   <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            scan_en <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!locked_bit) begin
                        div_cnt <= '0;
                        state   <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        key       <= decode_key(row_lock, col_lock);
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        state     <= PRESSED;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!locked_bit) begin
                        db_cnt <= '0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A return of the column here is release bounce, not a new press
                    if (locked_bit) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        key_down <= 1'b0;
                        div_cnt  <= '0;
                        state    <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed self-checking bench for keypad_decoder with default parameters.
module tb_keypad_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       scan_en;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    int tests_run    = 0;
    int tests_failed = 0;
    int scan_cnt     = 0;
    int valid_cnt    = 0;
    int up_cnt       = 0;

    keypad_decoder #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .scan_en   (scan_en),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (scan_en)   scan_cnt++;
        if (key_valid) valid_cnt++;
        if (!key_down) up_cnt++;
    endtask

    task automatic clearCounts();
        scan_cnt  = 0;
        valid_cnt = 0;
        up_cnt    = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input int n);
        rows = r;
        cols = c;
        repeat (n) tick();
    endtask

    task automatic waitKeyValid(input int limit, output int t, output bit found,
                                output int last_scan);
        t         = 0;
        found     = 1'b0;
        last_scan = -100;
        while (!found && t < limit) begin
            tick();
            t++;
            if (scan_en)   last_scan = t;
            if (key_valid) found = 1'b1;
        end
    endtask

    task automatic waitRelease(input int limit, output bit done);
        int t;
        t    = 0;
        done = !key_down;
        while (!done && t < limit) begin
            tick();
            t++;
            done = !key_down;
        end
    endtask

    initial begin
        int t;
        int last_scan;
        bit found;
        bit done;

        reset = 1'b1;
        rows  = 4'b0000;
        cols  = 4'b0000;
        tick();
        tick();
        checkOutput("rst_scan_en", 32'(scan_en), 32'd0);
        checkOutput("rst_key", 32'(key), 32'h0);
        checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_key_down", 32'(key_down), 32'd0);
        reset = 1'b0;

        applyStimulus(4'b0001, 4'b0000, 4);
        clearCounts();
        applyStimulus(4'b0001, 4'b0000, 16);
        checkOutput("idle_scan_pulses", 32'(scan_cnt), 32'd4);
        checkOutput("idle_key_valid", 32'(valid_cnt), 32'd0);
        checkOutput("idle_key", 32'(key), 32'h0);

        // Row 2, column 1 -> key 8
        clearCounts();
        rows = 4'b0100;
        cols = 4'b0010;
        waitKeyValid(20, t, found, last_scan);
        checkOutput("press8_found", 32'(found), 32'd1);
        checkOutput("press8_latency", 32'(t >= 11 && t <= 14), 32'd1);
        checkOutput("press8_key", 32'(key), 32'h8);
        checkOutput("press8_scan_frozen", 32'(t - last_scan > 8), 32'd1);
        tick();
        t++;
        checkOutput("press8_down", 32'(key_down), 32'd1);
        checkOutput("press8_pulse_width", 32'(key_valid), 32'd0);
        scan_cnt = 0;
        while (t < 20) begin
            tick();
            t++;
        end
        checkOutput("press8_valid_count", 32'(valid_cnt), 32'd1);
        checkOutput("press8_hold_scan", 32'(scan_cnt), 32'd0);

        clearCounts();
        applyStimulus(4'b0100, 4'b0000, 9);
        checkOutput("rel8_still_down", 32'(key_down), 32'd1);
        waitRelease(10, done);
        checkOutput("rel8_done", 32'(done), 32'd1);
        checkOutput("rel8_key_held", 32'(key), 32'h8);
        checkOutput("rel8_no_valid", 32'(valid_cnt), 32'd0);

        // Row 0, column 3 bouncing: never stable long enough
        clearCounts();
        repeat (10) begin
            applyStimulus(4'b0001, 4'b1000, 3);
            applyStimulus(4'b0001, 4'b0000, 1);
        end
        checkOutput("bounce_no_valid", 32'(valid_cnt), 32'd0);
        checkOutput("bounce_never_down", 32'(up_cnt), 32'd40);
        checkOutput("bounce_key_held", 32'(key), 32'h8);
        applyStimulus(4'b0001, 4'b0000, 4);
        clearCounts();
        applyStimulus(4'b0001, 4'b0000, 16);
        checkOutput("bounce_scan_resume", 32'(scan_cnt), 32'd4);

        clearCounts();
        applyStimulus(4'b0001, 4'b0110, 8);
        clearCounts();
        applyStimulus(4'b0001, 4'b0110, 16);
        checkOutput("twocol_scan", 32'(scan_cnt), 32'd4);
        checkOutput("twocol_no_valid", 32'(valid_cnt), 32'd0);

        clearCounts();
        applyStimulus(4'b0011, 4'b0001, 8);
        clearCounts();
        applyStimulus(4'b0011, 4'b0001, 16);
        checkOutput("tworow_scan", 32'(scan_cnt), 32'd4);
        checkOutput("tworow_not_down", 32'(up_cnt), 32'd16);

        // Row 1, column 1 -> key 5, then bounce on release
        clearCounts();
        rows = 4'b0010;
        cols = 4'b0010;
        waitKeyValid(20, t, found, last_scan);
        checkOutput("press5_found", 32'(found), 32'd1);
        checkOutput("press5_key", 32'(key), 32'h5);
        applyStimulus(4'b0010, 4'b0010, 4);
        clearCounts();
        applyStimulus(4'b0010, 4'b0000, 3);
        applyStimulus(4'b0010, 4'b0010, 10);
        checkOutput("relbounce_no_valid", 32'(valid_cnt), 32'd0);
        checkOutput("relbounce_stay_down", 32'(up_cnt), 32'd0);
        checkOutput("relbounce_no_scan", 32'(scan_cnt), 32'd0);

        clearCounts();
        applyStimulus(4'b0010, 4'b0000, 9);
        checkOutput("rel5_still_down", 32'(key_down), 32'd1);
        waitRelease(10, done);
        checkOutput("rel5_done", 32'(done), 32'd1);
        clearCounts();
        applyStimulus(4'b0010, 4'b0000, 16);
        checkOutput("rel5_scan_resume", 32'(scan_cnt), 32'd4);
        checkOutput("rel5_key_held", 32'(key), 32'h5);

        // Reset in the middle of debouncing row 3, column 2 (key F)
        clearCounts();
        applyStimulus(4'b1000, 4'b0100, 9);
        checkOutput("middb_no_valid", 32'(valid_cnt), 32'd0);
        checkOutput("middb_key_unchanged", 32'(key), 32'h5);
        reset = 1'b1;
        cols  = 4'b0000;
        tick();
        checkOutput("middb_rst_scan_en", 32'(scan_en), 32'd0);
        checkOutput("middb_rst_key", 32'(key), 32'h0);
        checkOutput("middb_rst_key_valid", 32'(key_valid), 32'd0);
        checkOutput("middb_rst_key_down", 32'(key_down), 32'd0);
        reset = 1'b0;
        clearCounts();
        applyStimulus(4'b1000, 4'b0000, 16);
        checkOutput("middb_scan_resume", 32'(scan_cnt), 32'd4);
        checkOutput("middb_no_valid_after", 32'(valid_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
